// File: rtl/branch_pred_unit_pkg.sv
// Shared definitions for the branch prediction unit: branch codes, counter
// states and the per-entry BTB metadata.
package bpu_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_RSVD = 3'b011;
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLT  = 3'b110;
  localparam logic [2:0] BR_BGE  = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Tag and target are XLEN-dependent, so they live in separate arrays.
  typedef struct packed {
    logic       valid;
    logic       is_jump;
    logic [1:0] ctr;
  } bpu_meta_t;

  function automatic logic br_taken(logic [2:0] code, logic less, logic zero);
    logic t;
    case (code)
      BR_JAL, BR_JALR: t = 1'b1;
      BR_BEQ:          t = zero;
      BR_BNE:          t = ~zero;
      BR_BLT:          t = less;
      BR_BGE:          t = ~less;
      default:         t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic br_eligible(logic [2:0] code);
    return (code != BR_NONE) && (code != BR_RSVD);
  endfunction

endpackage

// File: rtl/branch_pred_unit_if.sv
// Lookup / resolve / redirect / perf bundle between the pipeline and the BPU.
interface branch_pred_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [2:0]       ex_branch;
  logic             ex_less;
  logic             ex_zero;
  logic [XLEN-1:0]  ex_target;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;
  logic             flush;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] perf_br_cnt;
  logic [CNT_W-1:0] perf_mis_cnt;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_branch, ex_less, ex_zero, ex_target,
           ex_pred_taken, ex_pred_target, flush,
    input  pred_taken, pred_target, redirect_valid, redirect_pc, perf_br_cnt, perf_mis_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_branch, ex_less, ex_zero, ex_target,
           ex_pred_taken, ex_pred_target, flush,
    output pred_taken, pred_target, redirect_valid, redirect_pc, perf_br_cnt, perf_mis_cnt
  );
endinterface

// File: rtl/branch_pred_unit_sat_ctr2.sv
// 2-bit saturating up/down counter next-state function.
module sat_ctr2
  import bpu_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  output logic [1:0] ctr_o
);
  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
    end
  end
endmodule

// File: rtl/branch_pred_unit.sv
// Direct-mapped BTB with 2-bit direction counters, registered mispredict
// redirect and performance counters.
module branch_pred_unit
  import bpu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  branch_pred_unit_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  bpu_meta_t        meta_q [ENTRIES];
  bpu_meta_t        meta_d [ENTRIES];
  logic [TAG_W-1:0] tag_q  [ENTRIES];
  logic [TAG_W-1:0] tag_d  [ENTRIES];
  logic [XLEN-1:0]  tgt_q  [ENTRIES];
  logic [XLEN-1:0]  tgt_d  [ENTRIES];

  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             lk_hit, ex_hit, taken, upd_en, is_jmp, mispredict;
  logic [1:0]       ctr_nxt;
  logic [3:0]       unused_pc_lsb;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign if_tag = bus.if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = bus.ex_pc[IDX_W+1:2];
  assign ex_tag = bus.ex_pc[XLEN-1:IDX_W+2];
  assign unused_pc_lsb = {bus.if_pc[1:0], bus.ex_pc[1:0]};

  assign lk_hit = meta_q[if_idx].valid && (tag_q[if_idx] == if_tag);
  assign ex_hit = meta_q[ex_idx].valid && (tag_q[ex_idx] == ex_tag);

  assign taken  = br_taken(bus.ex_branch, bus.ex_less, bus.ex_zero);
  assign upd_en = bus.ex_valid && br_eligible(bus.ex_branch);
  assign is_jmp = (bus.ex_branch == BR_JAL) || (bus.ex_branch == BR_JALR);
  assign mispredict = bus.ex_valid &&
      ((taken != bus.ex_pred_taken) || (taken && (bus.ex_target != bus.ex_pred_target)));

  sat_ctr2 u_sat_ctr2 (
    .ctr_i (meta_q[ex_idx].ctr),
    .inc_i (taken),
    .ctr_o (ctr_nxt)
  );

  assign bus.pred_taken     = lk_hit && (meta_q[if_idx].is_jump || meta_q[if_idx].ctr[1]);
  assign bus.pred_target    = lk_hit ? tgt_q[if_idx] : '0;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.perf_br_cnt    = br_cnt_q;
  assign bus.perf_mis_cnt   = mis_cnt_q;

  always_comb begin
    meta_d = meta_q;
    tag_d  = tag_q;
    tgt_d  = tgt_q;
    if (bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) meta_d[i].valid = 1'b0;
    end else if (upd_en) begin
      if (ex_hit) begin
        meta_d[ex_idx].ctr     = ctr_nxt;
        meta_d[ex_idx].is_jump = is_jmp;
        if (taken) tgt_d[ex_idx] = bus.ex_target;
      end else begin
        meta_d[ex_idx] = '{valid: 1'b1, is_jump: is_jmp, ctr: (taken ? WT : WNT)};
        tag_d[ex_idx]  = ex_tag;
        tgt_d[ex_idx]  = bus.ex_target;
      end
    end else if (bus.ex_valid && ex_hit) begin
      // A non-branch now lives at this PC; drop the stale prediction.
      meta_d[ex_idx].valid = 1'b0;
    end
  end

  always_comb begin
    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    if (mispredict) redirect_pc_d = taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
    br_cnt_d  = upd_en ? br_cnt_q + CNT_W'(1) : br_cnt_q;
    mis_cnt_d = mispredict ? mis_cnt_q + CNT_W'(1) : mis_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        meta_q[i] <= '{valid: 1'b0, is_jump: 1'b0, ctr: WNT};
        tag_q[i]  <= '0;
        tgt_q[i]  <= '0;
      end
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      br_cnt_q         <= '0;
      mis_cnt_q        <= '0;
    end else begin
      meta_q           <= meta_d;
      tag_q            <= tag_d;
      tgt_q            <= tgt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      br_cnt_q         <= br_cnt_d;
      mis_cnt_q        <= mis_cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed self-checking bench for branch_pred_unit (XLEN=32, ENTRIES=16).
module tb_branch_pred_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  branch_pred_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

  branch_pred_unit #(.XLEN(32), .ENTRIES(16), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one resolving instruction for a single clock edge.
  task automatic resolve(input logic [31:0] pc, input logic [2:0] code, input logic less,
                         input logic zero, input logic [31:0] tgt, input logic ptk,
                         input logic [31:0] ptgt, input logic fl);
    bus.ex_valid       = 1'b1;
    bus.ex_pc          = pc;
    bus.ex_branch      = code;
    bus.ex_less        = less;
    bus.ex_zero        = zero;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptgt;
    bus.flush          = fl;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    bus.if_pc = pc;
    #1;
  endtask

  initial begin
    bus.if_pc = 32'h0; bus.ex_valid = 1'b0; bus.ex_pc = 32'h0; bus.ex_branch = 3'b000;
    bus.ex_less = 1'b0; bus.ex_zero = 1'b0; bus.ex_target = 32'h0;
    bus.ex_pred_taken = 1'b0; bus.ex_pred_target = 32'h0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    look(32'h8000_0000);
    chk("rst_pred_taken", {31'b0, bus.pred_taken}, 32'd0);
    chk("rst_pred_target", bus.pred_target, 32'h0);
    chk("rst_redir_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("rst_br_cnt", bus.perf_br_cnt, 32'd0);
    chk("rst_mis_cnt", bus.perf_mis_cnt, 32'd0);

    // beq taken, predicted not-taken; same-cycle lookup sees pre-update miss.
    look(32'h8000_0010);
    bus.ex_valid = 1'b1; bus.ex_pc = 32'h8000_0010; #1;
    chk("same_cycle_lookup", {31'b0, bus.pred_taken}, 32'd0);
    resolve(32'h8000_0010, 3'b100, 1'b0, 1'b1, 32'h8000_0040, 1'b0, 32'h0, 1'b0);
    chk("beq_redir_valid", {31'b0, bus.redirect_valid}, 32'd1);
    chk("beq_redir_pc", bus.redirect_pc, 32'h8000_0040);
    chk("beq_mis_cnt", bus.perf_mis_cnt, 32'd1);
    chk("beq_pred_taken", {31'b0, bus.pred_taken}, 32'd1);
    chk("beq_pred_target", bus.pred_target, 32'h8000_0040);

    // Not taken three times: ctr 10 -> 01 -> 00 -> 00.
    resolve(32'h8000_0010, 3'b100, 1'b0, 1'b0, 32'h8000_0040, 1'b1, 32'h8000_0040, 1'b0);
    chk("nt1_redir_valid", {31'b0, bus.redirect_valid}, 32'd1);
    chk("nt1_redir_pc", bus.redirect_pc, 32'h8000_0014);
    chk("nt1_pred_taken", {31'b0, bus.pred_taken}, 32'd0);
    chk("nt1_pred_target", bus.pred_target, 32'h8000_0040);
    resolve(32'h8000_0010, 3'b100, 1'b0, 1'b0, 32'h8000_0040, 1'b0, 32'h8000_0040, 1'b0);
    chk("nt2_redir_valid", {31'b0, bus.redirect_valid}, 32'd0);
    resolve(32'h8000_0010, 3'b100, 1'b0, 1'b0, 32'h8000_0040, 1'b0, 32'h8000_0040, 1'b0);
    chk("nt3_redir_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("nt3_pred_taken_sat", {31'b0, bus.pred_taken}, 32'd0);
    chk("nt3_br_cnt", bus.perf_br_cnt, 32'd4);
    chk("nt3_mis_cnt", bus.perf_mis_cnt, 32'd2);

    // Same index, different tag must miss.
    look(32'h8000_0050);
    chk("alias_tag_miss", bus.pred_target, 32'h0);

    // jalr with wrong predicted target.
    look(32'h8000_0020);
    resolve(32'h8000_0020, 3'b010, 1'b0, 1'b0, 32'h8000_0100, 1'b1, 32'h8000_0080, 1'b0);
    chk("jalr_redir_valid", {31'b0, bus.redirect_valid}, 32'd1);
    chk("jalr_redir_pc", bus.redirect_pc, 32'h8000_0100);
    chk("jalr_mis_cnt", bus.perf_mis_cnt, 32'd3);
    chk("jalr_pred_taken", {31'b0, bus.pred_taken}, 32'd1);
    chk("jalr_pred_target", bus.pred_target, 32'h8000_0100);

    // Correctly predicted jal: no redirect.
    resolve(32'h8000_0020, 3'b001, 1'b0, 1'b0, 32'h8000_0100, 1'b1, 32'h8000_0100, 1'b0);
    chk("jal_redir_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("jal_br_cnt", bus.perf_br_cnt, 32'd6);

    // Non-branch at a BTB-hit PC: mispredict, invalidate, no br count.
    look(32'h8000_0010);
    resolve(32'h8000_0010, 3'b000, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0040, 1'b0);
    chk("alias_redir_valid", {31'b0, bus.redirect_valid}, 32'd1);
    chk("alias_redir_pc", bus.redirect_pc, 32'h8000_0014);
    chk("alias_invalidated", bus.pred_target, 32'h0);
    chk("alias_br_cnt", bus.perf_br_cnt, 32'd6);
    chk("alias_mis_cnt", bus.perf_mis_cnt, 32'd4);

    // Reserved code behaves as none.
    resolve(32'h8000_0030, 3'b011, 1'b1, 1'b1, 32'h8000_0300, 1'b0, 32'h0, 1'b0);
    chk("rsvd_redir_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("rsvd_br_cnt", bus.perf_br_cnt, 32'd6);

    // Flush beats a simultaneous allocate; counters and redirect still update.
    resolve(32'h8000_0030, 3'b110, 1'b1, 1'b0, 32'h8000_0200, 1'b0, 32'h0, 1'b1);
    chk("flush_redir_valid", {31'b0, bus.redirect_valid}, 32'd1);
    chk("flush_redir_pc", bus.redirect_pc, 32'h8000_0200);
    chk("flush_br_cnt", bus.perf_br_cnt, 32'd7);
    chk("flush_mis_cnt", bus.perf_mis_cnt, 32'd5);
    look(32'h8000_0030);
    chk("flush_upd_miss", {31'b0, bus.pred_taken}, 32'd0);
    look(32'h8000_0020);
    chk("flush_old_miss", {31'b0, bus.pred_taken}, 32'd0);

    // Asynchronous reset drops a pending redirect immediately.
    resolve(32'h8000_0010, 3'b111, 1'b0, 1'b0, 32'h8000_0400, 1'b0, 32'h0, 1'b0);
    chk("pre_rst_redir_valid", {31'b0, bus.redirect_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_redir_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("mid_rst_mis_cnt", bus.perf_mis_cnt, 32'd0);
    chk("mid_rst_br_cnt", bus.perf_br_cnt, 32'd0);
    look(32'h8000_0010);
    chk("mid_rst_pred_taken", {31'b0, bus.pred_taken}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
